riscv_mdalu: RTL and testbench
==============================

# riscv_mdalu

Parametrised multi-cycle ALU for the RISC-V core's execute stage. Supersedes the single-cycle combinational ALU: it keeps the base logical, arithmetic and compare operations, adds XOR, the shifts and unsigned compare, and adds the RV32M multiply/divide group using an iterative 1-bit-per-cycle datapath. The execute stage talks to it through a valid/ready handshake on the operand side and on the result side, so it can stall for long operations.

## Interface
- `XLEN`, 32: operand and result width, ≥ 8, power of two.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand/op request.
- `in_ready` output 1: block can accept a request; high only in IDLE.
- `alu_ctl` input 5: operation select (see Operation).
- `a`, `b` input XLEN: operands.
- `flush` input 1: synchronous abort of any in-flight operation.
- `out_valid` output 1: result registered and held.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: registered result.
- `is_lt` output 1: registered; high when `result == 1` for SLT/SLTU, else 0.
- `zero` output 1: registered; `result == 0`.
- `busy` output 1: state is BUSY.

## Operation
- Single-cycle group:
  - `00000` AND
  - `00001` OR
  - `00010` ADD
  - `00110` SUB
  - `00111` SLT (signed)
  - `01000` SLTU
  - `01100` NOR
  - `00011` XOR
  - `00100` SLL
  - `00101` SRL
  - `01101` SRA
- Shift amount for SLL/SRL/SRA is `b[log2(XLEN)-1:0]`.
- ADD/SUB wrap modulo 2^XLEN.
- Any unlisted code returns result 0 as a single-cycle op.
- Iterative group:
  - `10000` MUL (low XLEN of product)
  - `10001` MULH (signed×signed, high half)
  - `10010` MULHU
  - `10011` MULHSU (a signed, b unsigned)
  - `10100` DIV
  - `10101` DIVU
  - `10110` REM
  - `10111` REMU
- Signed M ops:
  - Magnitudes are latched at accept.
  - The unsigned core runs on the magnitudes.
  - The sign is applied at completion.
  - DIV quotient sign is `a^b`; REM sign follows `a`.
- Multiply: 2·XLEN product register, shift-add, one bit of `b` per cycle.
- Divide: restoring, one quotient bit per cycle.
- Divide special cases (RISC-V defined; the computed result is overridden at completion and latency is unchanged):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give `a`.
  - DIV with `a` = most-negative and `b` = −1: quotient is most-negative; REM gives 0.
- FSM:
  - IDLE → (accept, single-cycle op) → DONE.
  - IDLE → (accept, iterative op) → BUSY.
  - BUSY → (counter reaches XLEN iterations) → DONE.
  - DONE → (`out_ready`) → IDLE.
- Accept condition is `in_valid && in_ready`. Operands and `alu_ctl` are latched at accept; later input changes are ignored.
- `flush` in any state returns to IDLE next edge:
  - Clears `out_valid` and the counter.
  - Discards the result.
  - A request presented in the same cycle as `flush` is not accepted.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 1
  - `out_valid` 0
  - `busy` 0
  - `result` 0
  - `is_lt` 0
  - `zero` 0
  - counter 0
- Reset asserted mid-operation aborts immediately (asynchronous); no result is produced.
- Accept at edge E:
  - Single-cycle op: `out_valid` = 1 after edge E+1.
  - Iterative op: `busy` = 1 after E, for exactly XLEN cycles; `out_valid` = 1 after edge E+XLEN+1.
- `result`, `is_lt` and `zero` change only on the edge that sets `out_valid`; stable while `out_valid` = 1.
- `out_valid` and `result` are held indefinitely while `out_ready` = 0.
- On the edge with `out_valid && out_ready`, `out_valid` clears and `in_ready` returns to 1. The next accept is possible one cycle later; there is no same-cycle turnaround.
- `in_ready` is registered-state-derived, never combinationally dependent on `in_valid`.

## Test plan
- Reset, then ADD with `a`=0xFFFFFFFF, `b`=1 (XLEN=32) → `out_valid` one edge after accept; `result`=0, `zero`=1, `is_lt`=0.
- SLT with `a`=0xFFFFFFFE, `b`=1 → `result`=1, `is_lt`=1. SLTU with the same operands → `result`=0, `is_lt`=0.
- MULH with `a`=0x80000000, `b`=0x80000000 → `result`=0x40000000 exactly 33 edges after accept; `busy` high for 32 cycles; `in_ready` low throughout.
- DIV with `a`=0x80000000, `b`=0xFFFFFFFF → 0x80000000. REM with the same operands → 0. DIVU with `a`=7, `b`=0 → 0xFFFFFFFF. REMU with `a`=7, `b`=0 → 7. All at full latency.
- DIVU with `a`=100, `b`=7 → 14; hold `out_ready`=0 for 10 cycles: `result` stays 14 and no new request is accepted despite `in_valid`=1.
- `flush` at iteration 10 of DIV → IDLE next edge, `out_valid` never asserts. Then a new SUB with `a`=5, `b`=7 → 0xFFFFFFFE. Separately, assert `rst_n`=0 mid-MUL → all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/riscv_mdalu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare/shift ops plus
// RV32M multiply/divide on a shared 1-bit-per-cycle shift-add / restoring datapath.
module riscv_mdalu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            is_lt,
  output logic            zero,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_XOR    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SLT    = 5'b00111;
  localparam logic [4:0] OP_SLTU   = 5'b01000;
  localparam logic [4:0] OP_NOR    = 5'b01100;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a request is taken on a rising edge where in_valid && in_ready
  // && !flush; a result is consumed on an edge where out_valid && out_ready.
  // Both sides hold their payload stable until the respective transfer edge.

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          ctl_q, ctl_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     mag_q, mag_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                is_lt_q, is_lt_d;
  logic                zero_q, zero_d;

  // Operand conditioning at accept time
  logic            in_iter;
  logic            in_is_div;
  logic            a_signed_op;
  logic            b_signed_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  always_comb begin
    in_iter     = (alu_ctl[4:3] == 2'b10);
    in_is_div   = alu_ctl[2];
    a_signed_op = (alu_ctl == OP_MULH) || (alu_ctl == OP_MULHSU) ||
                  (alu_ctl == OP_DIV)  || (alu_ctl == OP_REM);
    b_signed_op = (alu_ctl == OP_MULH) || (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
    a_mag       = (a_signed_op && a[XLEN-1]) ? -a : a;
    b_mag       = (b_signed_op && b[XLEN-1]) ? -b : b;
  end

  // One iteration of each unsigned core. acc_q is {hi, lo}: for multiply hi
  // accumulates and lo holds the remaining multiplier bits; for divide hi is
  // the partial remainder and lo shifts dividend bits out / quotient bits in.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Final result from latched operands and the finished core state
  logic [SW-1:0]     shamt;
  logic              mul_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic              b_is_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    shamt     = b_q[SW-1:0];
    mul_neg   = ((ctl_q == OP_MULH) && (a_q[XLEN-1] ^ b_q[XLEN-1])) ||
                ((ctl_q == OP_MULHSU) && a_q[XLEN-1]);
    prod_fix  = mul_neg ? -acc_q : acc_q;
    quot      = acc_q[XLEN-1:0];
    rem       = acc_q[2*XLEN-1:XLEN];
    b_is_zero = (b_q == '0);
    div_ovf   = (a_q == MOST_NEG) && (b_q == ALL_ONES);
    fin_res   = '0;
    unique case (ctl_q)
      OP_AND:    fin_res = a_q & b_q;
      OP_OR:     fin_res = a_q | b_q;
      OP_ADD:    fin_res = a_q + b_q;
      OP_SUB:    fin_res = a_q - b_q;
      OP_XOR:    fin_res = a_q ^ b_q;
      OP_NOR:    fin_res = ~(a_q | b_q);
      OP_SLT:    fin_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU:   fin_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      OP_SLL:    fin_res = a_q << shamt;
      OP_SRL:    fin_res = a_q >> shamt;
      OP_SRA:    fin_res = $signed(a_q) >>> shamt;
      OP_MUL:    fin_res = acc_q[XLEN-1:0];
      OP_MULH,
      OP_MULHU,
      OP_MULHSU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV: begin
        if (b_is_zero)                          fin_res = ALL_ONES;
        else if (div_ovf)                       fin_res = MOST_NEG;
        else if (a_q[XLEN-1] ^ b_q[XLEN-1])     fin_res = -quot;
        else                                    fin_res = quot;
      end
      OP_DIVU:   fin_res = b_is_zero ? ALL_ONES : quot;
      OP_REM: begin
        if (b_is_zero)        fin_res = a_q;
        else if (div_ovf)     fin_res = '0;
        else if (a_q[XLEN-1]) fin_res = -rem;
        else                  fin_res = rem;
      end
      OP_REMU:   fin_res = b_is_zero ? a_q : rem;
      default:   fin_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctl_d       = ctl_q;
    a_d         = a_q;
    b_d         = b_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    is_lt_d     = is_lt_q;
    zero_d      = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ctl_d = alu_ctl;
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          if (in_iter) begin
            state_d = S_BUSY;
            mag_d   = in_is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d = ctl_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle registers the result; afterwards wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = fin_res;
          is_lt_d     = ((ctl_q == OP_SLT) || (ctl_q == OP_SLTU)) && (fin_res == XLEN'(1));
          zero_d      = (fin_res == '0);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      result_d    = result_q;
      is_lt_d     = is_lt_q;
      zero_d      = zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ctl_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      is_lt_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctl_q       <= ctl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      is_lt_q     <= is_lt_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign is_lt     = is_lt_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_mdalu.sv
// Randomised and directed bench for riscv_mdalu (XLEN=32) against an
// arithmetic reference model with an expected-result queue.
module tb_riscv_mdalu;

  localparam int W = 32;

  localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010,
                         OP_XOR = 5'b00011, OP_SLL = 5'b00100, OP_SRL = 5'b00101,
                         OP_SUB = 5'b00110, OP_SLT = 5'b00111, OP_SLTU = 5'b01000,
                         OP_NOR = 5'b01100, OP_SRA = 5'b01101, OP_MUL = 5'b10000,
                         OP_MULH = 5'b10001, OP_MULHU = 5'b10010, OP_MULHSU = 5'b10011,
                         OP_DIV = 5'b10100, OP_DIVU = 5'b10101, OP_REM = 5'b10110,
                         OP_REMU = 5'b10111;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   alu_ctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         is_lt;
  logic         zero;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {is_lt, zero, result}
  logic [W+1:0] exp_q[$];

  riscv_mdalu #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .is_lt     (is_lt),
    .zero      (zero),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [4:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    longint sx, sy, ux, uy, p, q;
    logic [63:0] pv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    r  = '0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: r = (ux < uy) ? 32'd1 : 32'd0;
      OP_SLL:  r = x << y[4:0];
      OP_SRL:  r = x >> y[4:0];
      OP_SRA:  begin q = sx >>> y[4:0]; pv = q; r = pv[31:0]; end
      OP_MUL:  begin p = ux * uy; pv = p; r = pv[31:0]; end
      OP_MULH: begin p = sx * sy; pv = p; r = pv[63:32]; end
      OP_MULHU: begin p = ux * uy; pv = p; r = pv[63:32]; end
      OP_MULHSU: begin p = sx * uy; pv = p; r = pv[63:32]; end
      OP_DIV: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sx / sy; pv = q; r = pv[31:0]; end
      end
      OP_DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = sx % sy; pv = q; r = pv[31:0]; end
      end
      OP_REMU: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    model = {((op == OP_SLT || op == OP_SLTU) && r == 32'd1), (r == 0), r};
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold);
    int edges, busy_cyc;
    bit ready_low, stable, iter;
    logic [W+1:0] exp;
    iter = (op[4:3] == 2'b10);
    exp_q.push_back(model(op, av, bv));
    check_eq("ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    alu_ctl  = op;
    a        = av;
    b        = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctl  = 5'($urandom);
    a        = $urandom;
    b        = $urandom;
    edges = 0; busy_cyc = 0; ready_low = 1;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cyc++;
      if (in_ready) ready_low = 0;
      @(posedge clk); #1;
      edges++;
    end
    check_eq($sformatf("latency op=%0h", op), edges, iter ? W + 1 : 1);
    check_eq($sformatf("busy_cycles op=%0h", op), busy_cyc, iter ? W : 0);
    check_eq("ready_low_in_flight", ready_low, 1);
    exp = exp_q.pop_front();
    check_eq($sformatf("result op=%0h a=%0h b=%0h", op, av, bv), result, exp[W-1:0]);
    check_eq($sformatf("zero op=%0h", op), zero, exp[W]);
    check_eq($sformatf("is_lt op=%0h", op), is_lt, exp[W+1]);
    if (hold > 0) begin
      stable   = 1;
      in_valid = 1'b1;
      alu_ctl  = OP_ADD;
      for (int k = 0; k < hold; k++) begin
        a = $urandom;
        @(posedge clk); #1;
        if (!out_valid || result !== exp[W-1:0] || in_ready || busy) stable = 0;
      end
      in_valid = 1'b0;
      check_eq("hold_stable", stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("release_valid_ready", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_result"}, result, 0);
    check_eq({tag, "_is_lt"}, is_lt, 0);
    check_eq({tag, "_zero"}, zero, 0);
  endtask

  // Start an op and return #1 after its accept edge.
  task automatic start_op(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    alu_ctl  = op;
    a        = av;
    b        = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [4:0] valid_ops[19] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SRL, OP_SUB,
                                OP_SLT, OP_SLTU, OP_NOR, OP_SRA, OP_MUL, OP_MULH,
                                OP_MULHU, OP_MULHSU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  logic [W-1:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'hFFFF_FFFE};

  function automatic logic [W-1:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 20));
    return $urandom;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit quiet;
    logic [4:0] op;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctl   = '0;
    a         = '0;
    b         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_ADD,  32'hFFFF_FFFF, 32'h1, 0);
    run_op(OP_SLT,  32'hFFFF_FFFE, 32'h1, 0);
    run_op(OP_SLTU, 32'hFFFF_FFFE, 32'h1, 0);
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'd7, 32'd0, 0);
    run_op(OP_REMU, 32'd7, 32'd0, 0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd0, 0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 10);
    run_op(OP_SRA,  32'h8000_00F0, 32'h0000_0024, 0);
    run_op(5'b11111, 32'h1234_5678, 32'h1, 0);

    // Flush during iteration 10 of a DIV; a request in the flush cycle is ignored.
    start_op(OP_DIV, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctl  = OP_ADD;
    a        = 32'd1;
    b        = 32'd2;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_idle", {out_valid, busy, in_ready}, 3'b001);
    quiet = 1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid || !in_ready) quiet = 0;
      @(posedge clk); #1;
    end
    check_eq("flush_no_result", quiet, 1);
    run_op(OP_SUB, 32'd5, 32'd7, 0);

    // Asynchronous reset in the middle of a MUL.
    run_op(OP_ADD, 32'd3, 32'd4, 0);
    start_op(OP_MUL, 32'd12345, 32'd678);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    #2;
    rst_n = 1'b1;
    quiet = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) quiet = 0;
    end
    check_eq("reset_no_result", quiet, 1);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : valid_ops[$urandom_range(0, 18)];
      run_op(op, pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
